hazard_mc: RTL and testbench
============================

HAZARD_MC -- requirements
Module: hazard_mc

Interface
REQ-001 Parameter RAW, default 4: register-address width.
REQ-002 Parameter PC_IDX, default 15: register index never forwarded (PC).
REQ-003 Parameter MUL_LAT, default 3: multi-cycle MUL stall length in cycles, legal range 1..255.
REQ-004 Parameter DIV_LAT, default 16: multi-cycle DIV stall length in cycles, legal range 1..255.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESETn  in  1  asynchronous, active-low reset.
REQ-007 RA1D, RA2D  in  RAW  Decode source registers.
REQ-008 RA1E, RA2E, WA3E  in  RAW  Execute sources and destination.
REQ-009 MemtoRegE, RegWriteE, PCSrcE  in  1  Execute load, write-enable and branch-taken flags.
REQ-010 StartE, McOpE  in  1  Execute multi-cycle start; op select, 0=MUL, 1=DIV.
REQ-011 WA3M, RA2M  in  RAW; RegWriteM, MemWriteM  in  1  Memory-stage fields.
REQ-012 WA3W  in  RAW; RegWriteW, MemtoRegW  in  1  Writeback-stage fields.
REQ-013 ForwardAE, ForwardBE  out  2  operand select, 00 regfile, 01 W, 10 M.
REQ-014 ForwardM  out  1  store data taken from W result.
REQ-015 StallF, StallD, StallE  out  1  stage holds.
REQ-016 FlushD, FlushE, FlushM  out  1  stage bubbles.
REQ-017 McBusy, McDoneE  out  1  multi-cycle unit busy; result valid this cycle.

Function
REQ-018 ForwardAE SHALL be 10 if RA1E==WA3M & RegWriteM, else 01 if RA1E==WA3W & RegWriteW, else 00; ForwardBE identically on RA2E; M priority over W.
REQ-019 A source equal to PC_IDX SHALL always yield forward select 00.
REQ-020 ForwardM SHALL be (RA2M==WA3W) & MemWriteM & MemtoRegW & RegWriteW, and 0 when RA2M==PC_IDX.
REQ-021 LdStall SHALL be (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE.
REQ-022 Sub-FSM states IDLE, BUSY, DONE with an 8-bit down-counter cnt.
REQ-023 IDLE & StartE & !PCSrcE: cnt <= LAT-1 (LAT = McOpE ? DIV_LAT : MUL_LAT); next state BUSY if LAT>1, else DONE.
REQ-024 BUSY: cnt decrements each cycle; when cnt==1 the next state SHALL be DONE.
REQ-025 DONE: McDoneE=1 for exactly one cycle, next state IDLE; StartE in DONE SHALL be ignored (same instruction still in E).
REQ-026 McStall = (IDLE & StartE & !PCSrcE) | BUSY; exactly LAT stalled cycles per op.
REQ-027 StallF = StallD = LdStall | McStall; StallE = McStall; FlushM = McStall.
REQ-028 FlushD = PCSrcE; FlushE = PCSrcE | (LdStall & !McStall); McStall dominates LdStall so the multi-cycle op is never flushed.
REQ-029 PCSrcE in BUSY or DONE SHALL not alter FSM state or cnt.
REQ-030 McBusy = (state != IDLE).
REQ-031 Forwarding, flush and stall outputs are combinational; only FSM, cnt and counters are registered.

Reset
REQ-032 RESETn low SHALL immediately force state IDLE and cnt 0, including mid-operation.
REQ-033 Under reset, McBusy and McDoneE SHALL be 0, and all stall/flush outputs SHALL depend only on the combinational inputs.

Configuration
REQ-034 Macro HAZARD_MC_PERF_EN defined: add outputs StallCnt and FlushCnt, each 32 bits; StallCnt increments on each cycle StallD=1, FlushCnt on each cycle FlushE=1; both wrap at 2^32; both reset to 0.
REQ-035 Macro HAZARD_MC_PERF_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-036 Package hazard_pkg SHALL hold forward encodings FWD_RF=00, FWD_W=01, FWD_M=10, the FSM state typedef and the counter width constant.
REQ-037 The FSM and counter SHALL be sub-module mc_stall_ctrl (inputs StartE, McOpE, PCSrcE; outputs McStall, McBusy, McDoneE); all other logic in hazard_mc.

Verification
REQ-038 Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; with RA1E=WA3M=15 -> ForwardAE=00.
REQ-039 Load-use: MemtoRegE=RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0.
REQ-040 MUL: StartE=1, McOpE=0, MUL_LAT=3 held high -> StallE=1 for 3 cycles, McDoneE=1 on the 4th, no restart, then IDLE.
REQ-041 Overlap: DIV in BUSY while LdStall condition is true -> FlushE=0, StallE=1; PCSrcE=1 pulsed in BUSY -> counter unaffected.
REQ-042 Reset: RESETn low at cnt=7 of DIV -> McBusy=0 asynchronously; after release, StartE restarts a full DIV_LAT stall.
REQ-043 With HAZARD_MC_PERF_EN: 5 load-use cycles plus one 3-cycle MUL -> StallCnt=8, FlushCnt=5.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// multi-cycle FSM state type and counter widths.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int MC_CNT_W   = 8;
   localparam int PERF_CNT_W = 32;

   typedef logic [1:0] mc_state_t;

   localparam mc_state_t MC_IDLE = 2'd0;
   localparam mc_state_t MC_BUSY = 2'd1;
   localparam mc_state_t MC_DONE = 2'd2;

   // Memory stage wins over writeback; the PC is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic hit_m,
                                          input logic hit_w,
                                          input logic is_pc);
      if (is_pc)      return FWD_RF;
      else if (hit_m) return FWD_M;
      else if (hit_w) return FWD_W;
      else            return FWD_RF;
   endfunction

endpackage

// File: rtl/mc_stall_ctrl.sv
// Multi-cycle MUL/DIV sequencer: holds the pipeline for exactly LAT cycles
// and flags the single result-valid cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no op in flight; a StartE without branch launches one
//   BUSY    | op executing, cnt counts down to 1
//   DONE    | result valid this cycle, StartE of same op ignored
module mc_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 16
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic StartE,
   input  logic McOpE,
   input  logic PCSrcE,
   output logic McStall,
   output logic McBusy,
   output logic McDoneE
);

   localparam logic [MC_CNT_W-1:0] MUL_CNT0 = MC_CNT_W'(MUL_LAT - 1);
   localparam logic [MC_CNT_W-1:0] DIV_CNT0 = MC_CNT_W'(DIV_LAT - 1);

   mc_state_t             state_q, state_d;
   logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
   logic                  launch;
   logic                  lat_multi;

   assign launch    = (state_q == MC_IDLE) & StartE & ~PCSrcE;
   assign lat_multi = McOpE ? (DIV_LAT > 1) : (MUL_LAT > 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MC_IDLE: begin
            if (launch) begin
               cnt_d   = McOpE ? DIV_CNT0 : MUL_CNT0;
               state_d = lat_multi ? MC_BUSY : MC_DONE;
            end
         end
         MC_BUSY: begin
            cnt_d = cnt_q - {{(MC_CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == {{(MC_CNT_W-1){1'b0}}, 1'b1}) state_d = MC_DONE;
         end
         MC_DONE: state_d = MC_IDLE;
         default: begin
            state_d = MC_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign McStall = launch | (state_q == MC_BUSY);
   assign McBusy  = (state_q != MC_IDLE);
   assign McDoneE = (state_q == MC_DONE);

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard unit: operand forwarding, load-use and multi-cycle stalls,
// branch flushes. Define HAZARD_MC_PERF_EN to add stall/flush counters.
module hazard_mc
   import hazard_pkg::*;
#(
   parameter int RAW     = 4,
   parameter int PC_IDX  = 15,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 16
) (
   input  logic           CLK,
   input  logic           RESETn,
   input  logic [RAW-1:0] RA1D,
   input  logic [RAW-1:0] RA2D,
   input  logic [RAW-1:0] RA1E,
   input  logic [RAW-1:0] RA2E,
   input  logic [RAW-1:0] WA3E,
   input  logic           MemtoRegE,
   input  logic           RegWriteE,
   input  logic           PCSrcE,
   input  logic           StartE,
   input  logic           McOpE,
   input  logic [RAW-1:0] WA3M,
   input  logic [RAW-1:0] RA2M,
   input  logic           RegWriteM,
   input  logic           MemWriteM,
   input  logic [RAW-1:0] WA3W,
   input  logic           RegWriteW,
   input  logic           MemtoRegW,
   output logic [1:0]     ForwardAE,
   output logic [1:0]     ForwardBE,
   output logic           ForwardM,
   output logic           StallF,
   output logic           StallD,
   output logic           StallE,
   output logic           FlushD,
   output logic           FlushE,
   output logic           FlushM,
   output logic           McBusy,
`ifdef HAZARD_MC_PERF_EN
   output logic [PERF_CNT_W-1:0] StallCnt,
   output logic [PERF_CNT_W-1:0] FlushCnt,
`endif
   output logic           McDoneE
);

   localparam logic [RAW-1:0] PC_A = RAW'(PC_IDX);

   logic ld_stall;
   logic mc_stall;

   assign ForwardAE = fwd_sel((RA1E == WA3M) & RegWriteM,
                              (RA1E == WA3W) & RegWriteW,
                              (RA1E == PC_A));
   assign ForwardBE = fwd_sel((RA2E == WA3M) & RegWriteM,
                              (RA2E == WA3W) & RegWriteW,
                              (RA2E == PC_A));

   assign ForwardM = (RA2M == WA3W) & MemWriteM & MemtoRegW & RegWriteW
                     & (RA2M != PC_A);

   assign ld_stall = ((RA1D == WA3E) | (RA2D == WA3E)) & MemtoRegE & RegWriteE;

   mc_stall_ctrl #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_mc (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .StartE  (StartE),
      .McOpE   (McOpE),
      .PCSrcE  (PCSrcE),
      .McStall (mc_stall),
      .McBusy  (McBusy),
      .McDoneE (McDoneE)
   );

   assign StallF = ld_stall | mc_stall;
   assign StallD = ld_stall | mc_stall;
   assign StallE = mc_stall;
   assign FlushM = mc_stall;
   assign FlushD = PCSrcE;
   // A stalled multi-cycle op must stay in E, so the load-use bubble yields.
   assign FlushE = PCSrcE | (ld_stall & ~mc_stall);

`ifdef HAZARD_MC_PERF_EN
   logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallD) stall_cnt_q <= stall_cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
         if (FlushE) flush_cnt_q <= flush_cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Scoreboard bench for hazard_mc: stimulus pushes hand-computed expected
// output vectors, a negedge monitor pops and compares them.
module tb_hazard_mc;

   logic       CLK = 1'b0;
   logic       RESETn;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W;
   logic       MemtoRegE, RegWriteE, PCSrcE, StartE, McOpE;
   logic       RegWriteM, MemWriteM, RegWriteW, MemtoRegW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardM, StallF, StallD, StallE, FlushD, FlushE, FlushM;
   logic       McBusy, McDoneE;
`ifdef HAZARD_MC_PERF_EN
   logic [31:0] StallCnt, FlushCnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [12:0] exp;
   } sb_t;

   sb_t  sb_q[$];
   logic sample_en = 1'b0;

   always #5 CLK = ~CLK;

   hazard_mc dut (
      .CLK(CLK), .RESETn(RESETn),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
      .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
      .StartE(StartE), .McOpE(McOpE),
      .WA3M(WA3M), .RA2M(RA2M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .WA3W(WA3W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .McBusy(McBusy),
`ifdef HAZARD_MC_PERF_EN
      .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
      .McDoneE(McDoneE)
   );

   // {fae, fbe, fm, stallF, stallD, stallE, flushD, flushE, flushM, busy, done}
   function automatic logic [12:0] o(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic fm, input logic sf, input logic sd,
                                     input logic se, input logic fd, input logic fe,
                                     input logic fmm, input logic b, input logic d);
      return {fa, fb, fm, sf, sd, se, fd, fe, fmm, b, d};
   endfunction

   localparam logic [12:0] ZERO     = 13'b0;
   localparam logic [12:0] MC_LAUNCH = 13'b0_0000_1110_0100;
   localparam logic [12:0] MC_BUSYV  = 13'b0_0000_1110_0110;
   localparam logic [12:0] MC_DONEV  = 13'b0_0000_0000_0011;

   always @(negedge CLK) begin
      if (sample_en) begin
         logic [12:0] got;
         sb_t         e;
         got = {ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE,
                FlushD, FlushE, FlushM, McBusy, McDoneE};
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got %b, required a queued expectation", got);
         end else begin
            e = sb_q.pop_front();
            if (got !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got %b required %b", e.name, got, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   task automatic clr();
      {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W} = '0;
      {MemtoRegE, RegWriteE, PCSrcE, StartE, McOpE} = '0;
      {RegWriteM, MemWriteM, RegWriteW, MemtoRegW} = '0;
   endtask

   task automatic chk(input string nm, input logic [12:0] exp_v);
      sb_q.push_back('{nm, exp_v});
      sample_en = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESETn = 1'b0;
      clr();
      @(posedge CLK);
      #1;
      chk("reset_state", ZERO);
      RESETn = 1'b1;

      // Forwarding
      RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
      chk("fwd_m_priority", o(2'b10, 2'b00, 0,0,0,0,0,0,0,0,0));
      clr(); RA2E = 4'd6; WA3W = 4'd6; RegWriteW = 1'b1;
      chk("fwd_b_from_w", o(2'b00, 2'b01, 0,0,0,0,0,0,0,0,0));
      clr(); RA1E = 4'd3; WA3M = 4'd3; WA3W = 4'd4; RegWriteW = 1'b1;
      chk("fwd_no_regwrite", ZERO);
      clr(); RA1E = 4'd15; RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1;
      WA3W = 4'd15; RegWriteW = 1'b1;
      chk("fwd_pc_never", ZERO);
      clr(); RA2M = 4'd7; WA3W = 4'd7; MemWriteM = 1'b1; MemtoRegW = 1'b1; RegWriteW = 1'b1;
      chk("fwdm_hit", o(2'b00, 2'b00, 1,0,0,0,0,0,0,0,0));
      MemtoRegW = 1'b0;
      chk("fwdm_no_load", ZERO);
      MemtoRegW = 1'b1; RA2M = 4'd15; WA3W = 4'd15;
      chk("fwdm_pc", ZERO);

      // Load-use and branch
      clr(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
      chk("lduse_ra2", o(0,0,0,1,1,0,0,1,0,0,0));
      RA2D = 4'd0; RA1D = 4'd5;
      chk("lduse_ra1", o(0,0,0,1,1,0,0,1,0,0,0));
      RegWriteE = 1'b0;
      chk("lduse_no_write", ZERO);
      clr(); PCSrcE = 1'b1;
      chk("branch_flush", o(0,0,0,0,0,0,1,1,0,0,0));
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
      chk("branch_lduse", o(0,0,0,1,1,0,1,1,0,0,0));

      // MUL, StartE held through DONE
      clr(); StartE = 1'b1; McOpE = 1'b0;
      chk("mul_c0", MC_LAUNCH);
      chk("mul_c1", MC_BUSYV);
      chk("mul_c2", MC_BUSYV);
      chk("mul_done", MC_DONEV);
      StartE = 1'b0;
      chk("mul_idle", ZERO);

      // Start blocked by taken branch
      StartE = 1'b1; PCSrcE = 1'b1;
      chk("start_branch", o(0,0,0,0,0,0,1,1,0,0,0));
      clr();
      chk("start_branch_idle", ZERO);

      // DIV with load-use overlap and branch pulse in BUSY
      StartE = 1'b1; McOpE = 1'b1;
      chk("div_c0", MC_LAUNCH);
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
      chk("div_lduse_overlap", MC_BUSYV);
      PCSrcE = 1'b1;
      chk("div_branch_busy", o(0,0,0,1,1,1,1,1,1,1,0));
      PCSrcE = 1'b0; MemtoRegE = 1'b0; RegWriteE = 1'b0;
      for (int i = 3; i < 16; i++) chk($sformatf("div_c%0d", i), MC_BUSYV);
      chk("div_done", MC_DONEV);
      StartE = 1'b0;
      chk("div_idle", ZERO);

      // Async reset at cnt=7, then a full restart
      StartE = 1'b1;
      chk("div2_c0", MC_LAUNCH);
      for (int i = 1; i < 9; i++) chk($sformatf("div2_c%0d", i), MC_BUSYV);
      RESETn = 1'b0; StartE = 1'b0;
      chk("async_reset", ZERO);
      RESETn = 1'b1; StartE = 1'b1;
      chk("div3_c0", MC_LAUNCH);
      for (int i = 1; i < 16; i++) chk($sformatf("div3_c%0d", i), MC_BUSYV);
      chk("div3_done", MC_DONEV);
      StartE = 1'b0;
      chk("div3_idle", ZERO);

`ifdef HAZARD_MC_PERF_EN
      RESETn = 1'b0;
      chk("perf_reset", ZERO);
      RESETn = 1'b1;
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
      for (int i = 0; i < 5; i++) chk("perf_lduse", o(0,0,0,1,1,0,0,1,0,0,0));
      clr(); StartE = 1'b1;
      chk("perf_mul_c0", MC_LAUNCH);
      chk("perf_mul_c1", MC_BUSYV);
      chk("perf_mul_c2", MC_BUSYV);
      chk("perf_mul_done", MC_DONEV);
      StartE = 1'b0;
      chk("perf_idle", ZERO);
      n_tests++;
      if (StallCnt !== 32'd8) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d required 8", StallCnt);
      end
      n_tests++;
      if (FlushCnt !== 32'd5) begin
         n_fail++;
         $display("FAIL flush_cnt: got %0d required 5", FlushCnt);
      end
`endif

      sample_en = 1'b0;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
